distb_fir_serial: RTL and testbench

Bit-serial distributed-arithmetic FIR engine: a parametrised successor to the fixed 4-input coefficient table. It holds TAPS signed coefficients in run-time-writable registers and forms the 2^TAPS partial-sum table from them. It keeps a TAPS-deep sample delay line and computes one signed output per accepted input sample by walking the sample bits LSB-first through shift-accumulate. It sits between the sample source and the filter output stage of the distb FIR datapath.

---
 rtl/distb_fir_serial_if.sv | 28 ++
 rtl/distb_fir_serial.sv | 113 +++++++++++
 tb/tb_distb_fir_serial.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/distb_fir_serial_if.sv
// Sample, coefficient-write and result signals of the bit-serial DA FIR engine.
// The master side feeds samples and coefficients; the slave side is the engine.
interface distb_fir_serial_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TAPS       = 4,
   parameter int unsigned COEF_WIDTH = 12,
   parameter int unsigned OUT_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
);
   logic                         sclr;
   logic                         coef_wr;
   logic [$clog2(TAPS)-1:0]      coef_sel;
   logic signed [COEF_WIDTH-1:0] coef_in;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_data;
   logic                         out_valid;
   logic signed [OUT_WIDTH-1:0]  out_data;

   modport master (
      output sclr, coef_wr, coef_sel, coef_in, in_valid, in_data,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  sclr, coef_wr, coef_sel, coef_in, in_valid, in_data,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/distb_fir_serial.sv
// Bit-serial distributed-arithmetic FIR: one signed result per accepted sample,
// walking sample bits LSB-first through a coefficient partial-sum table.
module distb_fir_serial #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TAPS       = 4,
   parameter int unsigned COEF_WIDTH = 12,
   parameter int unsigned OUT_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
   input logic               clk,
   input logic               rst,
   distb_fir_serial_if.slave bus
);
   localparam int unsigned SEL_W = $clog2(TAPS);
   localparam int unsigned LUT_W = COEF_WIDTH + SEL_W;
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

   typedef enum logic {StIdle, StCalc} state_t;

   state_t                       state_q, state_d;
   logic signed [COEF_WIDTH-1:0] coef_q [TAPS];
   logic signed [DATA_WIDTH-1:0] taps_q [TAPS];
   logic signed [OUT_WIDTH-1:0]  acc_q, acc_d;
   logic signed [OUT_WIDTH-1:0]  out_data_q;
   logic                         out_valid_q;
   logic [BIT_W-1:0]             bit_q;
   logic signed [LUT_W-1:0]      lut;
   logic signed [OUT_WIDTH-1:0]  term;
   logic                         accept;
   logic                         last_bit;

   assign accept   = bus.in_valid && (state_q == StIdle) && !bus.sclr;
   assign last_bit = (bit_q == BIT_W'(DATA_WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.sclr) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc:  if (last_bit) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == StIdle);
      bus.out_valid = out_valid_q;
      bus.out_data  = out_data_q;
   end

   // Partial-sum table entry addressed by bit b of every tap.
   always_comb begin
      lut = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (taps_q[k][bit_q]) begin
            lut = lut + {{SEL_W{coef_q[k][COEF_WIDTH-1]}}, coef_q[k]};
         end
      end
   end

   // The sign bit of a two's complement sample carries negative weight.
   always_comb begin
      term  = {{(OUT_WIDTH - LUT_W){lut[LUT_W-1]}}, lut} <<< bit_q;
      acc_d = last_bit ? (acc_q - term) : (acc_q + term);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coef_q      <= '{default: '0};
         taps_q      <= '{default: '0};
         acc_q       <= '0;
         bit_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (bus.sclr) begin
            taps_q <= '{default: '0};
            acc_q  <= '0;
            bit_q  <= '0;
         end else if (state_q == StIdle) begin
            if (accept) begin
               taps_q[0] <= bus.in_data;
               for (int k = 1; k < TAPS; k++) begin
                  taps_q[k] <= taps_q[k-1];
               end
               acc_q <= '0;
               bit_q <= '0;
            end else if (bus.coef_wr && (int'(bus.coef_sel) < int'(TAPS))) begin
               coef_q[bus.coef_sel] <= bus.coef_in;
            end
         end else begin
            acc_q <= acc_d;
            bit_q <= bit_q + BIT_W'(1);
            if (last_bit) begin
               out_data_q  <= acc_d;
               out_valid_q <= 1'b1;
               bit_q       <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_distb_fir_serial.sv
// Directed bench for distb_fir_serial: a tap/coefficient model pushes expected
// results on accept; a monitor pops and compares them on every out_valid pulse.
module tb_distb_fir_serial;
   localparam int DW = 8;
   localparam int NT = 4;
   localparam int CW = 12;

   typedef struct {
      longint v;
      int     c;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   exp_t   sb[$];
   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   longint m_coef [NT];
   longint m_tap  [NT];
   longint last_out = 0;

   always #5 clk = ~clk;

   distb_fir_serial_if bus ();

   distb_fir_serial dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.out_valid === 1'b1) begin
         chk("out_valid_expected", (sb.size() > 0) ? 1 : 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_data", bus.out_data, e.v);
            chk("latency", cyc - e.c, DW + 1);
         end
         last_out = bus.out_data;
      end
   end

   task automatic send(input longint d, output int waits);
      longint s;
      int     c;
      bus.in_valid = 1'b1;
      bus.in_data  = d[DW-1:0];
      waits = 0;
      while (bus.in_ready !== 1'b1 && waits < 30) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 30) chk("ready_timeout", waits, 0);
      c = cyc;
      @(posedge clk);
      for (int k = NT - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = d;
      s = 0;
      for (int k = 0; k < NT; k++) s += m_coef[k] * m_tap[k];
      sb.push_back('{v: s, c: c});
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.in_ready !== 1'b1) && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 40) chk("drain_timeout", n, 0);
   endtask

   task automatic wcoef(input int sel, input longint v, input bit takes);
      bus.coef_wr  = 1'b1;
      bus.coef_sel = sel[1:0];
      bus.coef_in  = v[CW-1:0];
      @(negedge clk);
      bus.coef_wr = 1'b0;
      if (takes) m_coef[sel] = v;
   endtask

   task automatic set_coefs(input longint c0, input longint c1, input longint c2,
                            input longint c3);
      wcoef(0, c0, 1'b1);
      wcoef(1, c1, 1'b1);
      wcoef(2, c2, 1'b1);
      wcoef(3, c3, 1'b1);
   endtask

   initial begin
      longint imp [5];
      longint prev;
      longint d;
      int     w;
      imp = '{1, 0, 0, 0, 0};
      rst = 1'b1;
      bus.sclr = 1'b0;
      bus.coef_wr = 1'b0;
      bus.coef_sel = '0;
      bus.coef_in = '0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      for (int k = 0; k < NT; k++) begin
         m_coef[k] = 0;
         m_tap[k]  = 0;
      end
      repeat (2) @(negedge clk);
      chk("reset_in_ready", bus.in_ready, 1);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_out_data", bus.out_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // Impulse response
      set_coefs(41, 132, 341, 510);
      for (int i = 0; i < 5; i++) begin
         send(imp[i], w);
         drain();
      end
      chk("impulse_tail", last_out, 0);

      // Negative full scale
      bus.sclr = 1'b1;
      @(negedge clk);
      bus.sclr = 1'b0;
      for (int k = 0; k < NT; k++) m_tap[k] = 0;
      send(-128, w);
      drain();
      chk("neg_full_scale", last_out, -5248);
      set_coefs(-2048, -2048, -2048, -2048);
      for (int i = 0; i < NT; i++) begin
         send(-128, w);
         drain();
      end
      chk("max_positive", last_out, 1048576);

      // Continuous in_valid: 1 cycle ready, DW cycles busy
      set_coefs(41, 132, 341, 510);
      for (int i = 0; i < 8; i++) begin
         d = longint'($urandom_range(0, 255)) - 128;
         send(d, w);
         if (i > 0) chk("ready_low_cycles", w, DW);
      end
      drain();

      // Coefficient write in CALC cycle 3 is ignored
      send(3, w);
      repeat (2) @(negedge clk);
      wcoef(0, 100, 1'b0);
      drain();
      send(5, w);
      drain();
      chk("coef0_kept", last_out, 41 * 5 + 132 * 3 + 341 * m_tap[2] + 510 * m_tap[3]);
      wcoef(0, 100, 1'b1);
      send(1, w);
      drain();
      chk("coef0_idle_write", last_out, 100 + 132 * 5 + 341 * 3 + 510 * m_tap[3]);

      // sclr at CALC cycle 4
      wcoef(0, 41, 1'b1);
      prev = last_out;
      send(7, w);
      repeat (3) @(negedge clk);
      bus.sclr = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      bus.sclr = 1'b0;
      for (int k = 0; k < NT; k++) m_tap[k] = 0;
      chk("sclr_in_ready", bus.in_ready, 1);
      chk("sclr_hold_out", bus.out_data, prev);
      repeat (12) @(negedge clk);
      chk("sclr_no_result", bus.out_data, prev);
      send(1, w);
      drain();
      chk("after_sclr", last_out, 41);

      // Asynchronous reset mid-CALC
      send(9, w);
      @(negedge clk);
      #2;
      rst = 1'b1;
      void'(sb.pop_back());
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      for (int k = 0; k < NT; k++) begin
         m_coef[k] = 0;
         m_tap[k]  = 0;
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(1, w);
      drain();
      chk("post_rst_impulse", last_out, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
